// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit bridging execute to a handshaked data bus.
// Optional bus watchdog is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_port #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  if ((XLEN != 32 && XLEN != 64) || TIMEOUT_CYC < 1)
  begin : g_bad_cfg
    $error("lsu_mem_port: unsupported parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [OFF_W-1:0]  off_in;
  logic              illegal;
  logic              misal;
  logic              bad;
  logic [7:0]        mask8;
  logic [ADDR_W-1:0] addr_al;
  logic [XLEN-1:0]   wdata_sh;
  logic [STRB_W-1:0] strb_sh;
  logic              tmo;

  logic              we_q;
  logic [2:0]        op_q;
  logic [OFF_W-1:0]  off_q;

  logic [XLEN-1:0]   ld_shift;
  logic [XLEN-1:0]   ld_data;
  logic              ld_sign;
  int                ld_w;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_req   = (state == BUS);

  assign off_in   = req_addr[OFF_W-1:0];
  assign addr_al  = {req_addr[ADDR_W-1:OFF_W],
                     {OFF_W{1'b0}}};
  assign wdata_sh = req_wdata << {off_in, 3'b000};
  assign strb_sh  = STRB_W'(mask8) << off_in;
  assign bad      = illegal | misal;

  // Decode the incoming request: size mask, legality, alignment.
  always_comb begin
    illegal = (req_op == 3'b111);
    if (XLEN == 32) begin
      illegal = illegal | (req_op == 3'b011)
                        | (req_op == 3'b110);
    end
    misal = 1'b0;
    mask8 = 8'h01;
    unique case (req_op[1:0])
      2'd0: begin
        mask8 = 8'h01;
      end
      2'd1: begin
        mask8 = 8'h03;
        misal = req_addr[0];
      end
      2'd2: begin
        mask8 = 8'h0f;
        misal = |req_addr[1:0];
      end
      default: begin
        mask8 = 8'hff;
        misal = |req_addr[2:0];
      end
    endcase
  end

  // Align returned data to bit 0 and extend to XLEN.
  always_comb begin
    ld_shift = mem_rdata >> {off_q, 3'b000};
    ld_w     = XLEN;
    ld_sign  = 1'b0;
    unique case (op_q[1:0])
      2'd0: begin
        ld_w    = 8;
        ld_sign = ~op_q[2] & ld_shift[7];
      end
      2'd1: begin
        ld_w    = 16;
        ld_sign = ~op_q[2] & ld_shift[15];
      end
      2'd2: begin
        ld_w    = 32;
        ld_sign = ~op_q[2] & ld_shift[31];
      end
      default: begin
        ld_w    = XLEN;
        ld_sign = 1'b0;
      end
    endcase
    for (int i = 0; i < XLEN; i++) begin
      ld_data[i] = (i < ld_w) ? ld_shift[i] : ld_sign;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int TW = (TW_RAW < 8)  ? 8  :
                      (TW_RAW > 32) ? 32 : TW_RAW;

  logic [TW-1:0] tmo_cnt;

  // Watchdog: zero in the first BUS cycle, so the limit
  // is hit in the TIMEOUT_CYC-th cycle spent on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (state == BUS || state == WAIT) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign tmo = (state == BUS || state == WAIT) &&
               (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = bad ? RESP : BUS;
        end
      end
      BUS: begin
        if (mem_gnt) begin
          state_nxt = WAIT;
        end else if (tmo) begin
          state_nxt = RESP;
        end
      end
      WAIT: begin
        if (mem_rvalid || tmo) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, bus-side registers and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      op_q      <= 3'b000;
      off_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            op_q  <= req_op;
            off_q <= off_in;
            if (bad) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              mem_we    <= req_we;
              mem_addr  <= addr_al;
              mem_wdata <= req_we ? wdata_sh : '0;
              mem_wstrb <= req_we ? strb_sh : '0;
            end
          end
        end
        BUS: begin
          if (!mem_gnt && tmo) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= we_q ? '0 : ld_data;
          end else if (tmo) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
